// File: rtl/lcd_defs.sv
// Purpose : shared definitions for the HD44780 character LCD driver: command bytes,
//           FSM state and operation encodings, init-sequence table, us-to-cycles helper.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package lcd_defs;

    // HD44780 instruction bytes used by the driver
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display, cursor home
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;  // auto-increment address, no shift
    localparam logic [7:0] CMD_DDRAM_L1  = 8'h80;  // DDRAM address 0x00 (line 1 start)
    localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;  // DDRAM address 0x40 (line 2 start)

    // Waits of the HD44780 software-reset protocol after the first two function sets
    localparam int T_RST1_US = 4100;
    localparam int T_RST2_US = 100;

    // Number of commands in the power-on init sequence
    localparam int INIT_LEN = 7;

    typedef enum logic [2:0] {
        PWR_WAIT,
        BUS_SETUP,
        BUS_EHI,
        BUS_HOLD,
        BUS_EXEC,
        READY
    } state_e;

    // What the current bus cycle belongs to; selects exec time and what follows it
    typedef enum logic [1:0] {
        OP_INIT,
        OP_CLEAR,
        OP_DATA,
        OP_WRAP
    } op_e;

    function automatic int us_to_cycles(input int us, input int mhz);
        return us * mhz;
    endfunction

    // Command byte for each step of the init sequence
    function automatic logic [7:0] init_cmd(input logic [2:0] step);
        logic [7:0] cmd;
        case (step)
            3'd0, 3'd1, 3'd2, 3'd3: cmd = CMD_FUNC_8B2L;
            3'd4:                   cmd = CMD_DISP_ON;
            3'd5:                   cmd = CMD_CLEAR;
            default:                cmd = CMD_ENTRY_INC;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Purpose : single saturating down-counter used for every LCD wait (power-up, E width, exec).
// Latency : load takes effect next cycle; done is high while the count is zero.
// Backpressure: none; a load always wins over the decrement.
// Ports   : clk_i, rst_ni (async, active low, count resets to RESET_VAL),
//           load_i / load_val_i (count <= load_val_i), done_o (count == 0).
module lcd_delay_timer #(
    parameter int                WIDTH     = 20,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_char_driver.sv
// Purpose : HD44780 8-bit write-only character LCD driver: power-on init, one ASCII byte per
//           writeStart/writeDone handshake, display clear on clrLCD.
// Latency : writeStart to writeDone = 1 + EHI + 1 + T_CMD_US*CLK_MHZ cycles (plus one more bus
//           cycle when auto-wrap inserts a DDRAM address command).
// Backpressure: requests are honoured only while initDone=1; anything else is dropped, no queue.
// Ports   : clkLCD, resetLCD_n (async active low); data/writeStart/clrLCD request side;
//           initDone (READY), writeDone (1-cycle completion pulse); LCD_DB/LCD_RS/LCD_RW/LCD_E bus.
// Config  : define LCD_AUTOWRAP_EN to move the cursor to line 2 after 16 characters and back
//           to line 1 after 32.
module lcd_char_driver
    import lcd_defs::*;
#(
    parameter int CLK_MHZ  = 50,
    parameter int T_PWR_US = 15000,
    parameter int T_CMD_US = 40,
    parameter int T_CLR_US = 1640
) (
    input  logic       clkLCD,
    input  logic       resetLCD_n,
    input  logic [7:0] data,
    input  logic       writeStart,
    input  logic       clrLCD,
    output logic       initDone,
    output logic       writeDone,
    output logic [7:0] LCD_DB,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E
);

    localparam int TW  = $clog2(T_PWR_US * CLK_MHZ + 1);
    localparam int EHI = CLK_MHZ / 4 + 1;  // E high >= 250 ns

    // The timer reaches zero on the last cycle of a wait, so every load is (cycles - 1).
    localparam logic [TW-1:0] PWR_CYC = TW'(us_to_cycles(T_PWR_US, CLK_MHZ));
    localparam logic [TW-1:0] EHI_LD  = TW'(EHI - 1);
    localparam logic [TW-1:0] CMD_LD  = TW'(us_to_cycles(T_CMD_US, CLK_MHZ) - 1);
    localparam logic [TW-1:0] CLR_LD  = TW'(us_to_cycles(T_CLR_US, CLK_MHZ) - 1);
    localparam logic [TW-1:0] RST1_LD = TW'(us_to_cycles(T_RST1_US, CLK_MHZ) - 1);
    localparam logic [TW-1:0] RST2_LD = TW'(us_to_cycles(T_RST2_US, CLK_MHZ) - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  db_q, db_d;
    logic        rs_q, rs_d;
    logic        e_q, e_d;
`ifdef LCD_AUTOWRAP_EN
    logic [4:0]  cursor_q, cursor_d;
`endif

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic [TW-1:0] exec_ld;
    logic          write_done;

    // Timer comes out of reset already holding the power-up wait
    lcd_delay_timer #(
        .WIDTH     (TW),
        .RESET_VAL (PWR_CYC)
    ) u_timer (
        .clk_i      (clkLCD),
        .rst_ni     (resetLCD_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Execution wait of the command currently on the bus
    always_comb begin
        exec_ld = CMD_LD;
        case (op_q)
            OP_INIT: begin
                case (step_q)
                    3'd0:    exec_ld = RST1_LD;
                    3'd1:    exec_ld = RST2_LD;
                    3'd5:    exec_ld = CLR_LD;
                    default: exec_ld = CMD_LD;
                endcase
            end
            OP_CLEAR: exec_ld = CLR_LD;
            default:  exec_ld = CMD_LD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        step_d     = step_q;
        db_d       = db_q;
        rs_d       = rs_q;
        tmr_load   = 1'b0;
        tmr_val    = exec_ld;
        write_done = 1'b0;
`ifdef LCD_AUTOWRAP_EN
        cursor_d   = cursor_q;
`endif
        unique case (state_q)
            PWR_WAIT: begin
`ifdef LCD_AUTOWRAP_EN
                cursor_d = 5'd0;
`endif
                if (tmr_done) begin
                    state_d = BUS_SETUP;
                    op_d    = OP_INIT;
                    step_d  = 3'd0;
                    db_d    = init_cmd(3'd0);
                    rs_d    = 1'b0;
                end
            end
            BUS_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = EHI_LD;
                state_d  = BUS_EHI;
            end
            BUS_EHI: begin
                if (tmr_done) begin
                    state_d = BUS_HOLD;
                end
            end
            BUS_HOLD: begin
                tmr_load = 1'b1;
                tmr_val  = exec_ld;
                state_d  = BUS_EXEC;
            end
            BUS_EXEC: begin
                if (tmr_done) begin
                    case (op_q)
                        OP_INIT: begin
                            if (step_q == 3'(INIT_LEN - 1)) begin
                                state_d = READY;
                            end else begin
                                step_d  = step_q + 3'd1;
                                db_d    = init_cmd(step_q + 3'd1);
                                rs_d    = 1'b0;
                                state_d = BUS_SETUP;
                            end
                        end
                        OP_CLEAR: begin
                            state_d = READY;
                        end
                        OP_DATA: begin
`ifdef LCD_AUTOWRAP_EN
                            // Cursor was bumped when the byte was accepted: 16 means
                            // line 1 just filled, 0 means the 5-bit count wrapped past 31.
                            if (cursor_q == 5'd16) begin
                                op_d    = OP_WRAP;
                                db_d    = CMD_DDRAM_L2;
                                rs_d    = 1'b0;
                                state_d = BUS_SETUP;
                            end else if (cursor_q == 5'd0) begin
                                op_d    = OP_WRAP;
                                db_d    = CMD_DDRAM_L1;
                                rs_d    = 1'b0;
                                state_d = BUS_SETUP;
                            end else begin
                                write_done = 1'b1;
                                state_d    = READY;
                            end
`else
                            write_done = 1'b1;
                            state_d    = READY;
`endif
                        end
                        default: begin
                            // address command that followed a data write
                            write_done = 1'b1;
                            state_d    = READY;
                        end
                    endcase
                end
            end
            READY: begin
                // clear wins; a simultaneous write is dropped without writeDone
                if (clrLCD) begin
                    op_d    = OP_CLEAR;
                    db_d    = CMD_CLEAR;
                    rs_d    = 1'b0;
                    state_d = BUS_SETUP;
`ifdef LCD_AUTOWRAP_EN
                    cursor_d = 5'd0;
`endif
                end else if (writeStart) begin
                    op_d    = OP_DATA;
                    db_d    = data;
                    rs_d    = 1'b1;
                    state_d = BUS_SETUP;
`ifdef LCD_AUTOWRAP_EN
                    cursor_d = cursor_q + 5'd1;
`endif
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
        // E is registered off the next state so the strobe is glitch-free
        e_d = (state_d == BUS_EHI);
    end

    always_ff @(posedge clkLCD or negedge resetLCD_n) begin
        if (!resetLCD_n) begin
            state_q  <= PWR_WAIT;
            op_q     <= OP_INIT;
            step_q   <= 3'd0;
            db_q     <= 8'h00;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            cursor_q <= 5'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            step_q   <= step_d;
            db_q     <= db_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
`ifdef LCD_AUTOWRAP_EN
            cursor_q <= cursor_d;
`endif
        end
    end

    assign LCD_E     = e_q;
    assign LCD_DB    = db_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign initDone  = (state_q == READY);
    assign writeDone = write_done;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Purpose : self-checking bench for lcd_char_driver with a scoreboard of expected bus
//           commands and writeDone times, fed by randomized writes/clears at CLK_MHZ=1.
// Latency : n/a.
// Backpressure: stimulus waits for initDone before every request.
`timescale 1ns/1ps
module tb_lcd_char_driver;

    localparam int CLK_MHZ  = 1;
    localparam int T_PWR_US = 15000;
    localparam int T_CMD_US = 40;
    localparam int T_CLR_US = 1640;
    localparam int EHI      = CLK_MHZ / 4 + 1;
    // one command: setup + E high + hold + exec wait
    localparam int L_CMD    = 2 + EHI + T_CMD_US * CLK_MHZ;
    localparam int L_CLR    = 2 + EHI + T_CLR_US * CLK_MHZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       writeStart = 1'b0;
    logic       clrLCD = 1'b0;
    logic       initDone, writeDone, LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_DB;

    lcd_char_driver #(
        .CLK_MHZ  (CLK_MHZ),
        .T_PWR_US (T_PWR_US),
        .T_CMD_US (T_CMD_US),
        .T_CLR_US (T_CLR_US)
    ) dut (
        .clkLCD     (clk),
        .resetLCD_n (rst_n),
        .data       (data),
        .writeStart (writeStart),
        .clrLCD     (clrLCD),
        .initDone   (initDone),
        .writeDone  (writeDone),
        .LCD_DB     (LCD_DB),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_E      (LCD_E)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_bus[$];   // {RS, DB} of each expected E pulse, in order
    int         exp_done[$];  // cycle at which each writeDone is expected
    int         cur_model = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int init_len();
        int ex[7];
        int s;
        ex = '{4100, 100, T_CMD_US, T_CMD_US, T_CMD_US, T_CLR_US, T_CMD_US};
        s = 0;
        for (int i = 0; i < 7; i++) s += 2 + EHI + ex[i] * CLK_MHZ;
        return s;
    endfunction

    task automatic model_init();
        logic [7:0] seq[7];
        seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 7; i++) exp_bus.push_back({1'b0, seq[i]});
        cur_model = 0;
    endtask

    // ---------------- monitor: pops the scoreboard whenever the DUT presents something
    initial begin : monitor
        bit         e_prev;
        bit         wd_prev;
        int         ehi_cnt;
        logic [8:0] rise_val;
        logic [8:0] exp;
        int         t;
        e_prev = 0; wd_prev = 0; ehi_cnt = 0; rise_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_prev  = 0;
                wd_prev = 0;
            end else begin
                if (LCD_E && !e_prev) begin
                    rise_val = {LCD_RS, LCD_DB};
                    ehi_cnt  = 1;
                    check(LCD_RW == 1'b0, "lcd_rw", LCD_RW, 0);
                    if (exp_bus.size() == 0) begin
                        check(1'b0, "bus_unexpected_pulse", int'({LCD_RS, LCD_DB}), -1);
                    end else begin
                        exp = exp_bus.pop_front();
                        check({LCD_RS, LCD_DB} == exp, "bus_rs_db", int'({LCD_RS, LCD_DB}), int'(exp));
                    end
                end else if (LCD_E) begin
                    ehi_cnt++;
                end else if (e_prev) begin
                    check(ehi_cnt == EHI, "e_width", ehi_cnt, EHI);
                    check({LCD_RS, LCD_DB} == rise_val, "bus_hold", int'({LCD_RS, LCD_DB}), int'(rise_val));
                end
                if (writeDone) begin
                    check(!wd_prev, "wd_width", 2, 1);
                    if (exp_done.size() == 0) begin
                        check(1'b0, "wd_unexpected", cyc, -1);
                    end else begin
                        t = exp_done.pop_front();
                        check(cyc == t, "wd_latency", cyc, t);
                    end
                end
                e_prev  = LCD_E;
                wd_prev = writeDone;
            end
        end
    end

    // ---------------- helpers
    task automatic run_init();
        int c_r, first_e, n;
        c_r = cyc; first_e = -1; n = 0;
        while (!initDone && n < 40000) begin
            @(negedge clk);
            n++;
            if (LCD_E && first_e < 0) first_e = cyc;
        end
        check(initDone == 1'b1, "init_timeout", n, 40000);
        check(first_e - c_r >= T_PWR_US * CLK_MHZ && first_e - c_r <= T_PWR_US * CLK_MHZ + 3,
              "pwr_wait", first_e - c_r, T_PWR_US * CLK_MHZ);
        check(cyc - first_e == init_len() - 1, "init_len", cyc - first_e, init_len() - 1);
        check(exp_bus.size() == 0, "init_cmds_left", exp_bus.size(), 0);
    endtask

    // Issue one request in READY and wait for READY again; optionally poke a request mid-busy.
    task automatic issue(input bit wr, input bit clr, input logic [7:0] d, input int busy_at);
        int t0, n, lat;
        t0 = cyc;
        data = d; writeStart = wr; clrLCD = clr;
        if (clr) begin
            exp_bus.push_back({1'b0, 8'h01});
            cur_model = 0;
        end else if (wr) begin
            exp_bus.push_back({1'b1, d});
            lat = L_CMD;
`ifdef LCD_AUTOWRAP_EN
            cur_model = (cur_model + 1) % 32;
            if (cur_model == 16) begin
                exp_bus.push_back({1'b0, 8'hC0});
                lat += L_CMD;
            end else if (cur_model == 0) begin
                exp_bus.push_back({1'b0, 8'h80});
                lat += L_CMD;
            end
`endif
            exp_done.push_back(t0 + lat);
        end
        @(negedge clk);
        writeStart = 0; clrLCD = 0;
        if (clr) check(initDone == 1'b0, "clr_initdone_drop", initDone, 0);
        n = 1;
        while (!initDone && n < 5000) begin
            if (n == busy_at) begin
                writeStart = 1'b1;
                clrLCD     = 1'($urandom_range(0, 1));
                data       = 8'($urandom);
            end
            @(negedge clk);
            writeStart = 0; clrLCD = 0;
            n++;
        end
        check(initDone == 1'b1, "ready_timeout", n, 5000);
        if (clr) check(cyc - t0 == 1 + L_CLR, "clr_len", cyc - t0, 1 + L_CLR);
    endtask

    // ---------------- stimulus
    initial begin : stim
        int n;
        int r;
        repeat (3) @(negedge clk);
        check(LCD_E == 1'b0, "rst_e", LCD_E, 0);
        check(LCD_RS == 1'b0, "rst_rs", LCD_RS, 0);
        check(LCD_DB == 8'h00, "rst_db", LCD_DB, 0);
        check(initDone == 1'b0, "rst_initdone", initDone, 0);
        check(writeDone == 1'b0, "rst_writedone", writeDone, 0);

        rst_n = 1'b1;
        model_init();
        run_init();

        issue(1'b1, 1'b0, 8'h41, 0);           // plain write
        issue(1'b1, 1'b1, 8'h42, 0);           // clear beats write
        for (int i = 0; i < 33; i++)           // long run crosses both wrap points
            issue(1'b1, 1'b0, 8'($urandom_range(32, 126)), $urandom_range(0, L_CMD - 1));
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) issue(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), $urandom_range(0, 30));
            else       issue(1'b1, 1'b0, 8'($urandom), $urandom_range(0, L_CMD - 1));
        end

        // reset while E is high aborts the write and restarts init
        data = 8'h55; writeStart = 1'b1;
        exp_bus.push_back({1'b1, 8'h55});
        @(negedge clk);
        writeStart = 1'b0;
        n = 0;
        while (!LCD_E && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(LCD_E == 1'b1, "e_before_reset", LCD_E, 1);
        #1 rst_n = 1'b0;
        #1;
        check(LCD_E == 1'b0, "abort_e", LCD_E, 0);
        check(LCD_RS == 1'b0, "abort_rs", LCD_RS, 0);
        check(LCD_DB == 8'h00, "abort_db", LCD_DB, 0);
        check(initDone == 1'b0, "abort_initdone", initDone, 0);
        exp_bus.delete();
        exp_done.delete();
        cur_model = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_init();
        run_init();
        issue(1'b1, 1'b0, 8'h5A, 0);

        repeat (5) @(negedge clk);
        check(exp_bus.size() == 0, "bus_left", exp_bus.size(), 0);
        check(exp_done.size() == 0, "wd_left", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
